// File: rtl/inst_axi_bridge_pkg.sv
// Shared AXI4 read-channel constants and types for the instruction fetch bridge.
package inst_axi_bridge_pkg;

  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_RESP_W  = 2;
  localparam int unsigned AXI_LOCK_W  = 2;
  localparam int unsigned AXI_CACHE_W = 4;
  localparam int unsigned AXI_PROT_W  = 3;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [AXI_LEN_W-1:0]   AXI_LEN_SINGLE = 8'h00;

  // AR register slice: either empty or holding one request until the handshake.
  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_PEND = 1'b1
  } ar_state_e;

endpackage

// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the fetch-stage SRAM-like port to an AXI4 AR/R master.
// Single-beat in-order reads, up to OUTSTANDING requests in flight.
module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID      = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch-side SRAM-like port
  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        bus_err,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned CW = $clog2(OUTSTANDING + 1);

  ar_state_e               ar_state_q, ar_state_d;
  logic [AXI_ADDR_W-1:0]   araddr_q, araddr_d;
  logic [AXI_SIZE_W-1:0]   arsize_q, arsize_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    data_ok_q, data_ok_d;
  logic [AXI_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    bus_err_q, bus_err_d;

  logic                    addr_ok;
  logic                    r_hs;

  // Single ID and single beat: rid and rlast carry no information for us.
  logic unused_r_fields;
  assign unused_r_fields = ^{rid, rlast};

  // Request acceptance and R-channel readiness; nothing here depends on arready/rvalid
  // combinationally towards the fetch side.
  always_comb begin
    addr_ok = resetn & inst_sram_en & ~inst_sram_wr & (ar_state_q == AR_IDLE)
            & (count_q < CW'(OUTSTANDING));
    rready  = (count_q != '0);
    r_hs    = rvalid & rready;
  end

  // AR slice next state: load on accept, hold until handshake.
  always_comb begin
    ar_state_d = ar_state_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    unique case (ar_state_q)
      AR_IDLE: begin
        if (addr_ok) begin
          ar_state_d = AR_PEND;
          araddr_d   = inst_sram_addr;
          arsize_d   = {1'b0, inst_sram_size};
        end
      end
      AR_PEND: begin
        if (arready) ar_state_d = AR_IDLE;
      end
      default: ar_state_d = AR_IDLE;
    endcase
  end

  // Outstanding counter: accept and response in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({addr_ok, r_hs})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // R capture: one-cycle data_ok pulse, rdata holds after the pulse.
  always_comb begin
    data_ok_d = r_hs;
    bus_err_d = r_hs & (rresp != AXI_RESP_OKAY);
    rdata_d   = r_hs ? rdata : rdata_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state_q <= AR_IDLE;
      araddr_q   <= '0;
      arsize_q   <= '0;
      count_q    <= '0;
      data_ok_q  <= 1'b0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      ar_state_q <= ar_state_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
      count_q    <= count_d;
      data_ok_q  <= data_ok_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign inst_sram_addr_ok = addr_ok;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;
  assign bus_err           = bus_err_q;

  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = arsize_q;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = (ar_state_q == AR_PEND);

endmodule
